pipe_stage_reg: RTL
===================

// Module: pipe_stage_reg
// PURPOSE
//  Generic parametrised pipeline stage register replacing the fixed IF/ID, ID/EX, EX/MEM and MEM/WB registers.
//  Adds valid/ready backpressure, a one-entry skid buffer, flush (bubble insert) and saturating stall/bubble counters.
//  Packed stage structs from cpu_pkg connect through in_data/in_ctrl.
// PARAMETERS
//  DATA_W   107  width of packed data struct (default = ex_mem_data_t)
//  CTRL_W   6    width of packed control struct (default = ex_mem_control_t)
//  CNT_W    16   width of each performance counter
// PORTS
//  clock        in   1        rising-edge clock
//  reset        in   1        synchronous, active-low reset
//  in_valid     in   1        upstream has a valid entry
//  in_ready     out  1        stage can accept an entry this cycle
//  in_data      in   DATA_W   upstream data payload
//  in_ctrl      in   CTRL_W   upstream control payload
//  flush        in   1        kill all held and incoming entries this cycle
//  out_valid    out  1        stage holds a valid entry
//  out_ready    in   1        downstream accepts the entry this cycle
//  out_data     out  DATA_W   held data payload
//  out_ctrl     out  CTRL_W   held control payload; all-zero when out_valid=0
//  stall_count  out  CNT_W    cycles with out_valid=1 and out_ready=0
//  bubble_count out  CNT_W    cycles with out_valid=0 and out_ready=1
// BEHAVIOUR
//  - Reset (reset==0 at posedge) clears both entries:
//    * main_valid=0, skid_valid=0, data=0, ctrl=0, both counters=0.
//    * out_valid=0, in_ready=1 from the next cycle onward.
//  - Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  - Latency is 1 cycle: an entry accepted at edge N is on out_* after edge N.
//  - in_ready = !skid_valid. It is registered, with no combinational path from out_ready.
//  - Next-state rules, main entry:
//    * main empty, or main draining via out_fire: main loads skid if skid_valid, else loads in_fire data.
//  - Next-state rules, skid entry:
//    * main full, no out_fire, in_fire: entry goes to skid (skid_valid=1).
//    * skid empties when it moves to main; a simultaneous in_fire then refills skid.
//  - Ordering is strict FIFO: skid always drains before new input. Full throughput is 1 entry/cycle.
//  - Flush has priority over every handshake in the same cycle:
//    * main_valid and skid_valid clear to 0; an in_fire that cycle is consumed and dropped.
//    * ctrl registers clear to 0; data registers hold their value (don't-care).
//    * A flush while out_fire is high still counts as delivered downstream.
//  - out_ctrl is forced to '0 whenever out_valid=0. Bubbles never assert reg_write/mem_write etc.
//  - Counters:
//    * Increment at the posedge per the conditions above, sampled before flush.
//    * Saturate at 2^CNT_W-1 (no wrap); cleared only by reset.
//  - Reset mid-transfer: reset wins over flush and handshakes; entries are lost; in_ready=1 next cycle.
//  - Entries are never overwritten, duplicated or reordered:
//    * skid full + main full => in_ready=0.
// STRUCTURE
//  - cpu_pkg:
//    * All *_data_t / *_control_t stage structs and their $bits constants (IF_ID_*_W ... MEM_WB_*_W).
//    * Per-stage parameter sets for instantiation.
//  - Sub-module sat_counter #(CNT_W): clock, reset, inc -> count. Instantiated twice.
//  - Top holds the main/skid registers, handshake logic and output muxing.
// TESTING
//  1. Reset, in_valid=0 -> out_valid=0, out_ctrl=0, in_ready=1, counters=0 after the reset edge.
//  2. Streaming, out_ready=1:
//     * in_data.ALU_result=12345, rd=31, ctrl reg_write=1, one beat -> appears on out_* 1 cycle later.
//     * 5 back-to-back beats arrive in order with no gap.
//  3. Backpressure:
//     * 3 beats (10, 20, 30), out_ready=0 from beat 2 -> in_ready falls after beat 2 enters skid.
//     * Beat 3 is held upstream; out_ready=1 drains 10, 20, 30 in order.
//     * stall_count equals the number of blocked cycles.
//  4. Flush:
//     * main+skid full (10, 20), flush=1 with in_valid=1 (30) -> next cycle out_valid=0, out_ctrl=0, in_ready=1.
//     * 30 never appears.
//  5. Saturation: CNT_W=4, out_valid=0, out_ready=1 for 20 cycles -> bubble_count=15 and stays at 15.
//  6. Reset mid-operation: reset=0 while skid full and out_ready=0 -> all valids 0, counters 0, in_ready=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared pipeline stage structs and their packed widths.
// Each stage register is an instance of pipe_stage_reg sized from these constants.
package cpu_pkg;

  // IF/ID: fetched instruction and its address
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_data_t;

  typedef struct packed {
    logic predicted_taken;
  } if_id_control_t;

  // ID/EX: decoded operands heading into the ALU
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
  } id_ex_data_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic [3:0] alu_op;
  } id_ex_control_t;

  // EX/MEM: ALU result plus store data (107 bits)
  typedef struct packed {
    logic [31:0] ALU_result;
    logic [31:0] write_data;
    logic [31:0] pc_plus4;
    logic [4:0]  rd;
    logic [4:0]  rs2;
    logic        zero;
  } ex_mem_data_t;

  typedef struct packed {
    logic reg_write;
    logic mem_write;
    logic mem_read;
    logic mem_to_reg;
    logic branch;
    logic jump;
  } ex_mem_control_t;

  // MEM/WB: value to be written back
  typedef struct packed {
    logic [31:0] ALU_result;
    logic [31:0] read_data;
    logic [31:0] pc_plus4;
    logic [4:0]  rd;
  } mem_wb_data_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic jump;
  } mem_wb_control_t;

  // Per-stage parameter sets for pipe_stage_reg instances
  localparam int IF_ID_DATA_W  = $bits(if_id_data_t);
  localparam int IF_ID_CTRL_W  = $bits(if_id_control_t);
  localparam int ID_EX_DATA_W  = $bits(id_ex_data_t);
  localparam int ID_EX_CTRL_W  = $bits(id_ex_control_t);
  localparam int EX_MEM_DATA_W = $bits(ex_mem_data_t);
  localparam int EX_MEM_CTRL_W = $bits(ex_mem_control_t);
  localparam int MEM_WB_DATA_W = $bits(mem_wb_data_t);
  localparam int MEM_WB_CTRL_W = $bits(mem_wb_control_t);

  localparam int PERF_CNT_W    = 16;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter used for the stage's stall and bubble statistics.
// It sticks at all-ones instead of wrapping; only reset brings it back to zero.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CountMax = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CountOne = {{(CNT_W-1){1'b0}}, 1'b1};

  // Count one event per cycle, holding once the maximum value is reached
  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != CountMax)) begin
      count <= count + CountOne;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake.
// A main entry drives the outputs; a one-entry skid catches the beat that arrives
// in the cycle downstream stalls, so in_ready can be a plain register.
module pipe_stage_reg
  import cpu_pkg::*;
#(
  parameter int DATA_W = EX_MEM_DATA_W,
  parameter int CTRL_W = EX_MEM_CTRL_W,
  parameter int CNT_W  = PERF_CNT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  bubble_count
);

  logic              mainValid;
  logic [DATA_W-1:0] mainData;
  logic [CTRL_W-1:0] mainCtrl;
  logic              skidValid;
  logic [DATA_W-1:0] skidData;
  logic [CTRL_W-1:0] skidCtrl;

  logic inFire;
  logic outFire;
  logic mainFree;

  // The skid flag is itself a flop, so in_ready never depends on out_ready
  assign in_ready  = !skidValid;
  assign inFire    = in_valid && in_ready;
  assign outFire   = mainValid && out_ready;
  assign mainFree  = !mainValid || outFire;

  assign out_valid = mainValid;
  assign out_data  = mainData;
  assign out_ctrl  = mainValid ? mainCtrl : '0;

  // Main/skid entry update: skid always drains into main before new input is taken
  always_ff @(posedge clock) begin
    if (!reset) begin
      mainValid <= 1'b0;
      mainData  <= '0;
      mainCtrl  <= '0;
      skidValid <= 1'b0;
      skidData  <= '0;
      skidCtrl  <= '0;
    end else if (flush) begin
      mainValid <= 1'b0;
      mainCtrl  <= '0;
      skidValid <= 1'b0;
      skidCtrl  <= '0;
    end else if (mainFree) begin
      if (skidValid) begin
        mainValid <= 1'b1;
        mainData  <= skidData;
        mainCtrl  <= skidCtrl;
        skidValid <= inFire;
        if (inFire) begin
          skidData <= in_data;
          skidCtrl <= in_ctrl;
        end
      end else begin
        mainValid <= inFire;
        if (inFire) begin
          mainData <= in_data;
          mainCtrl <= in_ctrl;
        end
      end
    end else if (inFire) begin
      skidValid <= 1'b1;
      skidData  <= in_data;
      skidCtrl  <= in_ctrl;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_counter (
    .clock (clock),
    .reset (reset),
    .inc   (mainValid && !out_ready),
    .count (stall_count)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_bubble_counter (
    .clock (clock),
    .reset (reset),
    .inc   (!mainValid && out_ready),
    .count (bubble_count)
  );

endmodule
